dmem_req_ctrl: RTL and testbench

Request controller between the core's memory stage and `data_mem`. It accepts one load/store request per handshake and screens it for size encoding and alignment. It then drives `data_mem` with a single-cycle `memread`/`memwrite` strobe and holds the bus stable while `data_mem` asserts `clk_stall`. When the access completes it returns the load result, or an error, to the pipeline with a one-cycle response pulse.

---
 rtl/dmem_req_ctrl.sv | 131 +++++++++++++
 tb/tb_dmem_req_ctrl.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_req_ctrl.sv
// Load/store request controller in front of data_mem: screens size and alignment,
// issues a one-cycle strobe, waits out clk_stall with a timeout, returns a response pulse.
module dmem_req_ctrl #(
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_mask,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        busy,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_write_data,
    output logic [3:0]  mem_sign_mask,
    output logic        mem_memread,
    output logic        mem_memwrite,
    input  logic [31:0] mem_read_data,
    input  logic        mem_clk_stall
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    // IDLE accept | STROBE one-cycle memread/memwrite | GUARD ignore stall | WAIT poll stall | RESP reply
    typedef enum logic [2:0] {
        S_IDLE,
        S_STROBE,
        S_GUARD,
        S_WAIT,
        S_RESP
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [31:0]        r_mem_addr;
    logic [31:0]        r_mem_wdata;
    logic [3:0]         r_mem_mask;
    logic               r_write;
    logic               r_err;
    logic [31:0]        r_rdata;
    logic [CNT_W-1:0]   r_cnt;

    logic [2:0]         w_size;
    logic               w_size_ok;
    logic               w_misaligned;
    logic               w_bad;
    logic               w_cnt_tc;

    assign w_size       = req_mask[2:0];
    assign w_size_ok    = (w_size == 3'b001) || (w_size == 3'b011) || (w_size == 3'b111);
    assign w_misaligned = ((w_size == 3'b011) && req_addr[0]) ||
                          ((w_size == 3'b111) && (req_addr[1:0] != 2'b00));
    assign w_bad        = !w_size_ok || w_misaligned;
    assign w_cnt_tc     = (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (req_valid) w_next = w_bad ? S_RESP : S_STROBE;
            S_STROBE: w_next = S_GUARD;
            S_GUARD:  w_next = S_WAIT;
            S_WAIT:   if (!mem_clk_stall || w_cnt_tc) w_next = S_RESP;
            S_RESP:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_mask  <= '0;
            r_write     <= 1'b0;
            r_err       <= 1'b0;
            r_rdata     <= '0;
            r_cnt       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_mem_addr  <= req_addr;
                        r_mem_wdata <= req_wdata;
                        r_mem_mask  <= req_mask;
                        r_write     <= req_write;
                        r_err       <= w_bad;
                        if (w_bad) r_rdata <= '0;
                    end
                end
                S_GUARD: r_cnt <= '0;
                S_WAIT: begin
                    if (!mem_clk_stall) begin
                        r_rdata <= r_write ? 32'h0 : mem_read_data;
                    end else if (w_cnt_tc) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_RESP:  r_err <= 1'b0;
                default: ;
            endcase
        end
    end

    // Handshake and strobes decode straight from state so reset drops them asynchronously.
    assign req_ready      = (r_state == S_IDLE);
    assign busy           = (r_state != S_IDLE);
    assign resp_valid     = (r_state == S_RESP);
    assign resp_err       = r_err;
    assign resp_rdata     = r_rdata;
    assign mem_memread    = (r_state == S_STROBE) && !r_write;
    assign mem_memwrite   = (r_state == S_STROBE) && r_write;
    assign mem_addr       = r_mem_addr;
    assign mem_write_data = r_mem_wdata;
    assign mem_sign_mask  = r_mem_mask;

endmodule

// File: tb/tb_dmem_req_ctrl.sv
// Bench for dmem_req_ctrl: a byte-array data_mem model with programmable stall, directed
// scenarios and a randomized request stream checked against a latency/data reference.
module tb_dmem_req_ctrl;

    localparam int T = 8;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_write = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [3:0]  req_mask = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic        busy;
    logic [31:0] mem_addr;
    logic [31:0] mem_write_data;
    logic [3:0]  mem_sign_mask;
    logic        mem_memread;
    logic        mem_memwrite;
    logic [31:0] mem_read_data;
    logic        mem_clk_stall;

    int tests = 0;
    int fails = 0;

    dmem_req_ctrl #(.TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_mask(req_mask),
        .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
        .busy(busy), .mem_addr(mem_addr), .mem_write_data(mem_write_data),
        .mem_sign_mask(mem_sign_mask), .mem_memread(mem_memread),
        .mem_memwrite(mem_memwrite), .mem_read_data(mem_read_data),
        .mem_clk_stall(mem_clk_stall)
    );

    always #5 clk = ~clk;

    // data_mem model: stall high from the cycle after the strobe for model_stall+1 cycles
    logic [7:0] dm_mem [4096];
    logic [7:0] ref_mem [4096];
    bit         dm_ready = 1'b0;
    int         model_stall = 0;
    int         stall_cnt;

    assign mem_clk_stall = (stall_cnt > 0);

    function automatic logic [7:0] pat(input int i);
        return 8'((i * 73 + 29) ^ (i >> 4));
    endfunction

    function automatic int nbytes(input logic [3:0] m);
        return (m[2:0] == 3'b001) ? 1 : (m[2:0] == 3'b011) ? 2 : 4;
    endfunction

    function automatic logic [31:0] ext(input logic [31:0] raw, input logic [3:0] m);
        case (m[2:0])
            3'b001:  return m[3] ? {{24{raw[7]}}, raw[7:0]} : {24'h0, raw[7:0]};
            3'b011:  return m[3] ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
            default: return raw;
        endcase
    endfunction

    function automatic logic [31:0] dm_raw(input int i);
        return {dm_mem[(i + 3) & 4095], dm_mem[(i + 2) & 4095], dm_mem[(i + 1) & 4095], dm_mem[i & 4095]};
    endfunction

    function automatic logic [31:0] ref_raw(input int i);
        return {ref_mem[(i + 3) & 4095], ref_mem[(i + 2) & 4095], ref_mem[(i + 1) & 4095], ref_mem[i & 4095]};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if (!dm_ready) begin
                for (int i = 0; i < 4096; i++) dm_mem[i] = pat(i);
                dm_ready = 1'b1;
            end
            stall_cnt     <= 0;
            mem_read_data <= '0;
        end else begin
            if (mem_memwrite) begin
                for (int b = 0; b < nbytes(mem_sign_mask); b++)
                    dm_mem[(int'(mem_addr[11:0]) + b) & 4095] = mem_write_data[8*b +: 8];
            end
            if (mem_memread)
                mem_read_data <= ext(dm_raw(int'(mem_addr[11:0])), mem_sign_mask);
            if (mem_memread || mem_memwrite) stall_cnt <= model_stall + 1;
            else if (stall_cnt > 0)          stall_cnt <= stall_cnt - 1;
        end
    end

    task automatic ref_store(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] m);
        for (int b = 0; b < nbytes(m); b++) ref_mem[(int'(a[11:0]) + b) & 4095] = wd[8*b +: 8];
    endtask

    // Issues one request and measures it; cycle j=1 is the cycle after the accepting edge.
    task automatic run_req(input logic w, input logic [31:0] a, input logic [31:0] wd,
                           input logic [3:0] m, input int ns,
                           output int lat, output logic e, output logic [31:0] rd,
                           output int nstb, output logic stb_ok, output logic busy_ok);
        lat = -1; e = 1'bx; rd = 'x; nstb = 0; stb_ok = 1'b1; busy_ok = 1'b1;
        @(negedge clk);
        for (int t = 0; t < 100 && !req_ready; t++) @(negedge clk);
        model_stall = ns;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = wd; req_mask = m;
        @(posedge clk);
        for (int j = 1; j <= 200; j++) begin
            @(negedge clk);
            if (busy !== 1'b1 || req_ready !== 1'b0) busy_ok = 1'b0;
            if (mem_memread || mem_memwrite) begin
                nstb++;
                if (mem_addr !== a || mem_write_data !== wd || mem_sign_mask !== m ||
                    mem_memwrite !== w || mem_memread !== !w) stb_ok = 1'b0;
            end
            if (j == 1) begin
                req_valid = 1'b0; req_write = 1'($urandom);
                req_addr = $urandom; req_wdata = $urandom; req_mask = 4'($urandom);
            end
            if (resp_valid === 1'b1) begin
                lat = j; e = resp_err; rd = resp_rdata;
                break;
            end
        end
    endtask

    task automatic test_reset();
        #3;
        tests++;
        if ({resp_valid, resp_err, busy, mem_memread, mem_memwrite, resp_rdata, mem_addr,
             mem_write_data, mem_sign_mask} !== '0) begin
            fails++;
            $display("FAIL reset_outputs: got busy=%b rv=%b addr=%h rdata=%h, expected all zero",
                     busy, resp_valid, mem_addr, resp_rdata);
        end
        tests++;
        if (req_ready !== 1'b1) begin
            fails++; $display("FAIL reset_ready: got %b expected 1", req_ready);
        end
        @(negedge clk); rst_n = 1'b1;
    endtask

    task automatic test_store_byte();
        int lat, nstb; logic e, sok, bok; logic [31:0] rd;
        run_req(1'b1, 32'h400, 32'hAAA, 4'b0001, 3, lat, e, rd, nstb, sok, bok);
        ref_store(32'h400, 32'hAAA, 4'b0001);
        tests++; if (nstb !== 1 || sok !== 1'b1) begin fails++; $display("FAIL store_strobe: got count=%0d ok=%b expected 1/1", nstb, sok); end
        tests++; if (lat !== 7) begin fails++; $display("FAIL store_latency: got %0d expected 7", lat); end
        tests++; if (e !== 1'b0 || rd !== 32'h0) begin fails++; $display("FAIL store_resp: got err=%b rdata=%h expected 0/0", e, rd); end
    endtask

    task automatic test_signed_load();
        int lat, nstb; logic e, sok, bok; logic [31:0] rd;
        run_req(1'b0, 32'h400, 32'h0, 4'b1001, 5, lat, e, rd, nstb, sok, bok);
        tests++; if (nstb !== 1 || sok !== 1'b1) begin fails++; $display("FAIL sload_strobe: got count=%0d ok=%b expected 1/1", nstb, sok); end
        tests++; if (rd !== 32'hFFFF_FFAA || e !== 1'b0) begin fails++; $display("FAIL sload_data: got %h err=%b expected ffffffaa err=0", rd, e); end
        tests++; if (lat !== 9) begin fails++; $display("FAIL sload_latency: got %0d expected 9", lat); end
        tests++; if (bok !== 1'b1) begin fails++; $display("FAIL sload_busy: got busy not held, expected busy high throughout"); end
    endtask

    task automatic test_errors();
        logic [31:0] addrs [3];
        logic [3:0]  masks [3];
        int lat, nstb; logic e, sok, bok; logic [31:0] rd;
        addrs[0] = 32'h101; masks[0] = 4'b0011;
        addrs[1] = 32'h42;  masks[1] = 4'b0111;
        addrs[2] = 32'h400; masks[2] = 4'b0101;
        for (int i = 0; i < 3; i++) begin
            run_req(1'(i), addrs[i], 32'h1234_5678, masks[i], 0, lat, e, rd, nstb, sok, bok);
            tests++;
            if (lat !== 1 || e !== 1'b1 || nstb !== 0 || rd !== 32'h0) begin
                fails++;
                $display("FAIL err_case%0d: got lat=%0d err=%b strobes=%0d rdata=%h expected 1/1/0/0",
                         i, lat, e, nstb, rd);
            end
        end
    endtask

    task automatic test_timeout();
        int lat, nstb; logic e, sok, bok; logic [31:0] rd;
        run_req(1'b0, 32'h400, 32'h0, 4'b0111, 100000, lat, e, rd, nstb, sok, bok);
        tests++; if (lat !== T + 3) begin fails++; $display("FAIL timeout_latency: got %0d expected %0d", lat, T + 3); end
        tests++; if (e !== 1'b1 || rd !== 32'h0) begin fails++; $display("FAIL timeout_resp: got err=%b rdata=%h expected 1/0", e, rd); end
        @(negedge clk);
        tests++; if (req_ready !== 1'b1 || busy !== 1'b0 || resp_valid !== 1'b0) begin fails++; $display("FAIL timeout_idle: got ready=%b busy=%b expected 1/0", req_ready, busy); end
    endtask

    task automatic test_back_to_back();
        int r1 = -1, s2 = -1, r2 = -1;
        logic rdy_after = 1'b0, e2 = 1'bx;
        logic [31:0] rd2 = 'x;
        @(negedge clk);
        for (int t = 0; t < 100 && !req_ready; t++) @(negedge clk);
        model_stall = 0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h40; req_wdata = 32'hAAAA_AAAA; req_mask = 4'b0111;
        @(posedge clk);
        for (int j = 1; j <= 60; j++) begin
            @(negedge clk);
            if (r1 > 0 && j == r1 + 1) rdy_after = req_ready;
            if (r1 > 0 && j == r1 + 2) req_valid = 1'b0;
            if (r1 < 0 && resp_valid) begin
                r1 = j; req_write = 1'b0; req_wdata = 32'h0;
            end else if (r1 > 0 && s2 < 0 && mem_memread) begin
                s2 = j;
            end else if (r1 > 0 && r2 < 0 && resp_valid) begin
                r2 = j; rd2 = resp_rdata; e2 = resp_err;
                break;
            end
        end
        req_valid = 1'b0;
        ref_store(32'h40, 32'hAAAA_AAAA, 4'b0111);
        tests++; if (r1 !== 4) begin fails++; $display("FAIL b2b_first_latency: got %0d expected 4", r1); end
        tests++; if (rdy_after !== 1'b1 || s2 !== r1 + 2) begin fails++; $display("FAIL b2b_second_accept: got strobe cycle %0d ready=%b expected %0d/1", s2, rdy_after, r1 + 2); end
        tests++; if (r2 !== r1 + 5) begin fails++; $display("FAIL b2b_second_latency: got %0d expected %0d", r2, r1 + 5); end
        tests++; if (rd2 !== 32'hAAAA_AAAA || e2 !== 1'b0) begin fails++; $display("FAIL b2b_load_data: got %h err=%b expected aaaaaaaa/0", rd2, e2); end
    endtask

    task automatic test_reset_mid_wait();
        int seen = 0, lat, nstb; logic e, sok, bok; logic [31:0] rd;
        @(negedge clk);
        for (int t = 0; t < 100 && !req_ready; t++) @(negedge clk);
        model_stall = 20;
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; req_wdata = 32'h0; req_mask = 4'b0111;
        @(posedge clk);
        @(negedge clk); req_valid = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests++;
        if ({resp_valid, resp_err, busy, mem_memread, mem_memwrite, resp_rdata, mem_addr,
             mem_write_data, mem_sign_mask} !== '0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL async_reset: got busy=%b ready=%b addr=%h rdata=%h expected 0/1/0/0",
                     busy, req_ready, mem_addr, resp_rdata);
        end
        @(negedge clk); rst_n = 1'b1;
        for (int j = 0; j < 30; j++) begin
            @(negedge clk);
            if (resp_valid) seen++;
        end
        tests++; if (seen !== 0) begin fails++; $display("FAIL reset_no_resp: got %0d responses expected 0", seen); end
        run_req(1'b0, 32'h40, 32'h0, 4'b0111, 2, lat, e, rd, nstb, sok, bok);
        tests++; if (lat !== 6 || rd !== 32'hAAAA_AAAA || e !== 1'b0 || nstb !== 1) begin fails++; $display("FAIL post_reset_load: got lat=%0d rdata=%h err=%b expected 6/aaaaaaaa/0", lat, rd, e); end
    endtask

    task automatic test_random();
        logic [3:0] mtab [7];
        mtab[0] = 4'b0001; mtab[1] = 4'b0011; mtab[2] = 4'b0111; mtab[3] = 4'b1001;
        mtab[4] = 4'b1011; mtab[5] = 4'b1111; mtab[6] = 4'b0000;
        for (int n = 0; n < 40; n++) begin
            logic w, bad, to, e, sok, bok, e_exp;
            logic [31:0] a, wd, rd, rd_exp;
            logic [3:0] m;
            int ns, lat, nstb, lat_exp, sel;
            w   = 1'($urandom);
            a   = 32'($urandom_range(0, 4095));
            wd  = $urandom;
            sel = $urandom_range(0, 6);
            m   = (sel == 6) ? 4'($urandom) : mtab[sel];
            ns  = $urandom_range(0, 10);
            bad = !(m[2:0] == 3'b001 || m[2:0] == 3'b011 || m[2:0] == 3'b111) ||
                  (m[2:0] == 3'b011 && a[0]) || (m[2:0] == 3'b111 && a[1:0] != 2'b00);
            to      = !bad && (ns >= T);
            e_exp   = bad || to;
            lat_exp = bad ? 1 : (to ? T + 3 : ns + 4);
            rd_exp  = (e_exp || w) ? 32'h0 : ext(ref_raw(int'(a[11:0])), m);
            run_req(w, a, wd, m, ns, lat, e, rd, nstb, sok, bok);
            if (!bad && w) ref_store(a, wd, m);
            tests++; if (lat !== lat_exp) begin fails++; $display("FAIL rnd%0d_latency: got %0d expected %0d", n, lat, lat_exp); end
            tests++; if (e !== e_exp || rd !== rd_exp) begin fails++; $display("FAIL rnd%0d_resp: got err=%b rdata=%h expected %b/%h", n, e, rd, e_exp, rd_exp); end
            tests++; if (nstb !== (bad ? 0 : 1) || sok !== 1'b1 || bok !== 1'b1) begin fails++; $display("FAIL rnd%0d_bus: got strobes=%0d ok=%b busy_ok=%b expected %0d/1/1", n, nstb, sok, bok, bad ? 0 : 1); end
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ref_mem[i] = pat(i);
        test_reset();
        test_store_byte();
        test_signed_load();
        test_errors();
        test_timeout();
        test_back_to_back();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
